rip_trap_ctrl: RTL and testbench
================================

Name: rip_trap_ctrl

Overview:
Machine-mode trap, CSR and core-mode controller for the rip core. Sits beside the EX stage: takes decoded ECALL/EBREAK/MRET/EXT/CSR* events, owns the csr_t register set and the core_mode_t state, and sequences pipeline flush, stall and PC redirect for traps, trap return, start and exit.

Parameters:
RESET_PC, 32'h0000_0000, PC issued on start.
MTVEC_RESET, 32'h0000_0100, reset value of mtvec.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; leave FINISHED and begin execution
ex_valid  in  1  EX-stage instruction valid this cycle
ex_pc  in  32  PC of EX instruction
ex_inst  in  rip_type::inst_t  decoded EX instruction
ex_illegal  in  1  EX instruction is illegal
csr_addr  in  12  CSR address (ex_inst.CSRR*)
csr_wsrc  in  32  rs1 value or zero-extended uimm
csr_rdata  out  32  combinational read of csr_addr
pipe_empty  in  1  no instruction in flight past EX
stall  out  1  freeze fetch..EX
flush  out  1  kill IF/ID/EX contents
redirect  out  1  load redirect_pc into PC
redirect_pc  out  32  redirect target
mode  out  rip_type::core_mode_t  current core mode
done  out  1  one-cycle pulse on entering FINISHED from EXITPROC
csr  out  rip_type::csr_t  current CSR values

Behaviour:
- Clock clk; reset rst is synchronous, active-high; all state updates on rising clk.
- States: S_FIN, S_RUN, S_TRAP, S_REDIR, S_DRAIN. Reset -> S_FIN; mode=FINISHED, mstatus=0, mtvec=MTVEC_RESET, mepc=0, mcause=0, cycle=0, stall=0, flush=0, redirect=0, redirect_pc=0, done=0.
- mode: S_FIN=FINISHED; S_RUN/S_TRAP/S_REDIR=RUNNING; S_DRAIN=EXITPROC.
- S_FIN: stall=1. start=1 -> cycle<=0, target<=RESET_PC, go S_REDIR.
- S_RUN: stall=0. Event accepted only when ex_valid=1; priority ex_illegal > ECALL > EBREAK > MRET > EXT > CSRR*; lower events in the same cycle are dropped.
  - Trap (illegal/ECALL/EBREAK): mepc<=ex_pc; mcause<=2/11/3; mstatus[7] (MPIE)<=mstatus[3] (MIE); MIE<=0; mstatus[12:11]<=2'b11; target<={mtvec[31:2],2'b00}; go S_TRAP.
  - MRET: MIE<=MPIE; MPIE<=1; target<=mepc; go S_TRAP.
  - EXT or EXTX: go S_DRAIN.
  - CSRRW/CSRRWI: csr<=wsrc. CSRRS/CSRRSI: csr<=csr|wsrc. CSRRC/CSRRCI: csr<=csr&~wsrc. The S/C forms skip the write when wsrc=0. Stay S_RUN.
- CSR map: 0x300 mstatus, 0x305 mtvec, 0x341 mepc (bits[1:0] forced 0 on write), 0x342 mcause, 0xC00 cycle (read-only; writes ignored). Unmapped: read 0, write ignored. csr_rdata shows the pre-write value.
- S_TRAP: one cycle; flush=1, stall=1 -> S_REDIR.
- S_REDIR: one cycle; redirect=1, redirect_pc=target, stall=1 -> S_RUN.
- Trap/MRET latency: event accepted in cycle N; flush in N+1; redirect in N+2; S_RUN in N+3.
- S_DRAIN: stall=1, flush=0. pipe_empty=1 -> S_FIN with done=1 for exactly one cycle. Otherwise wait indefinitely.
- cycle: +1 every clk while not in S_FIN; wraps 32'hFFFF_FFFF->0; the CSR write path never modifies it.
- start is ignored outside S_FIN. ex_* inputs are ignored when not in S_RUN.
- Reset asserted in any state overrides everything the same edge, including a trap in progress.

Test Plan:
- Reset then start -> cycle+1 redirect=1, redirect_pc=0x0, mode=RUNNING; cycle counter=1 in the cycle after S_REDIR.
- In S_RUN, ECALL at ex_pc=0x40, mtvec=0x103, mstatus=0x8 -> mepc=0x40, mcause=11, mstatus=0x1880; flush at N+1; redirect_pc=0x100 at N+2.
- MRET after the above trap -> mstatus MIE=1, MPIE=1; redirect_pc=0x40 at N+2.
- CSRRS 0x300 wsrc=0 with mstatus=0x8 -> csr_rdata=0x8, no write. CSRRW 0xC00 wsrc=5 -> cycle is unchanged. CSRRC 0x305 wsrc=0x100 with mtvec=0x103 -> mtvec=0x003.
- ex_illegal=1 and ECALL in the same cycle -> mcause=2. ex_valid=0 with ECALL set -> no event.
- EXT with pipe_empty=0 for 3 cycles, then 1 -> mode=EXITPROC for 3+ cycles, then FINISHED, done=1 for exactly 1 cycle. rst asserted during S_TRAP -> all reset values on the next edge.

Source files
------------

// File: rtl/rip_trap_ctrl.sv
// Machine-mode trap, CSR and core-mode controller for the rip core.
// Owns the CSR set and core mode; sequences flush, stall and PC redirect around EX.

package rip_type;

  typedef enum logic [1:0] {
    FINISHED = 2'd0,
    RUNNING  = 2'd1,
    EXITPROC = 2'd2
  } core_mode_t;

  typedef struct packed {
    logic ECALL;
    logic EBREAK;
    logic MRET;
    logic EXT;
    logic EXTX;
    logic CSRRW;
    logic CSRRS;
    logic CSRRC;
    logic CSRRWI;
    logic CSRRSI;
    logic CSRRCI;
  } inst_t;

  typedef struct packed {
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] cycle;
  } csr_t;

endpackage

module rip_trap_ctrl
  import rip_type::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  inst_t       ex_inst,
  input  logic        ex_illegal,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wsrc,
  output logic [31:0] csr_rdata,
  input  logic        pipe_empty,
  output logic        stall,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output core_mode_t  mode,
  output logic        done,
  output csr_t        csr
);

  typedef enum logic [2:0] {
    S_FIN,
    S_RUN,
    S_TRAP,
    S_REDIR,
    S_DRAIN
  } state_t;

  state_t      state, next_state;
  csr_t        csr_q, csr_d;
  logic [31:0] target_q, target_d;
  logic        stall_d, flush_d, redirect_d, done_d;
  logic [31:0] redirect_pc_d;

  logic        is_trap, is_rw, is_rs, is_rc, csr_wen;
  logic [31:0] csr_wval;

  assign csr = csr_q;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      12'h300: csr_rdata = csr_q.mstatus;
      12'h305: csr_rdata = csr_q.mtvec;
      12'h341: csr_rdata = csr_q.mepc;
      12'h342: csr_rdata = csr_q.mcause;
      12'hC00: csr_rdata = csr_q.cycle;
      default: csr_rdata = '0;
    endcase
  end

  always_comb begin
    case (state)
      S_FIN:   mode = FINISHED;
      S_DRAIN: mode = EXITPROC;
      default: mode = RUNNING;
    endcase
  end

  // Set/clear forms with a zero source must not write, so side effects stay tied to real writes.
  always_comb begin
    is_trap  = ex_illegal | ex_inst.ECALL | ex_inst.EBREAK;
    is_rw    = ex_inst.CSRRW | ex_inst.CSRRWI;
    is_rs    = ex_inst.CSRRS | ex_inst.CSRRSI;
    is_rc    = ex_inst.CSRRC | ex_inst.CSRRCI;
    csr_wen  = is_rw | ((is_rs | is_rc) & (csr_wsrc != 32'd0));
    csr_wval = is_rw ? csr_wsrc
             : is_rs ? (csr_rdata | csr_wsrc)
             :         (csr_rdata & ~csr_wsrc);
  end

  always_comb begin
    next_state = state;
    csr_d      = csr_q;
    target_d   = target_q;
    done_d     = 1'b0;

    if (state != S_FIN) csr_d.cycle = csr_q.cycle + 32'd1;

    case (state)
      S_FIN: begin
        if (start) begin
          csr_d.cycle = '0;
          target_d    = RESET_PC;
          next_state  = S_REDIR;
        end
      end
      S_RUN: begin
        if (ex_valid) begin
          if (is_trap) begin
            csr_d.mepc          = ex_pc;
            csr_d.mcause        = ex_illegal ? 32'd2 : ex_inst.ECALL ? 32'd11 : 32'd3;
            csr_d.mstatus[7]    = csr_q.mstatus[3];
            csr_d.mstatus[3]    = 1'b0;
            csr_d.mstatus[12:11] = 2'b11;
            target_d            = {csr_q.mtvec[31:2], 2'b00};
            next_state          = S_TRAP;
          end else if (ex_inst.MRET) begin
            csr_d.mstatus[3] = csr_q.mstatus[7];
            csr_d.mstatus[7] = 1'b1;
            target_d         = csr_q.mepc;
            next_state       = S_TRAP;
          end else if (ex_inst.EXT | ex_inst.EXTX) begin
            next_state = S_DRAIN;
          end else if (csr_wen) begin
            case (csr_addr)
              12'h300: csr_d.mstatus = csr_wval;
              12'h305: csr_d.mtvec   = csr_wval;
              12'h341: csr_d.mepc    = {csr_wval[31:2], 2'b00};
              12'h342: csr_d.mcause  = csr_wval;
              default: ;
            endcase
          end
        end
      end
      S_TRAP:  next_state = S_REDIR;
      S_REDIR: next_state = S_RUN;
      S_DRAIN: begin
        if (pipe_empty) begin
          next_state = S_FIN;
          done_d     = 1'b1;
        end
      end
      default: next_state = S_FIN;
    endcase

    // Control outputs are registered from the state being entered, so they line up with it.
    stall_d       = (next_state != S_RUN);
    flush_d       = (next_state == S_TRAP);
    redirect_d    = (next_state == S_REDIR);
    redirect_pc_d = redirect_d ? target_d : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FIN;
      csr_q       <= '{mstatus: '0, mtvec: MTVEC_RESET, mepc: '0, mcause: '0, cycle: '0};
      target_q    <= '0;
      stall       <= 1'b0;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      done        <= 1'b0;
    end else begin
      state       <= next_state;
      csr_q       <= csr_d;
      target_q    <= target_d;
      stall       <= stall_d;
      flush       <= flush_d;
      redirect    <= redirect_d;
      redirect_pc <= redirect_pc_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_rip_trap_ctrl.sv
// Directed bench for rip_trap_ctrl: reset, start, CSR ops, trap/MRET sequencing, exit and reset mid-trap.

module tb_rip_trap_ctrl;
  import rip_type::*;

  logic        clk = 1'b0;
  logic        rst, start, ex_valid, ex_illegal, pipe_empty;
  logic [31:0] ex_pc, csr_wsrc;
  inst_t       ex_inst;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata, redirect_pc;
  logic        stall, flush, redirect, done;
  core_mode_t  mode;
  csr_t        csr;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_cycle = 32'd0;
  bit          in_fin = 1'b1;

  always #5 clk = ~clk;

  rip_trap_ctrl #(.RESET_PC(32'h0000_0000), .MTVEC_RESET(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .start(start), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_inst(ex_inst), .ex_illegal(ex_illegal), .csr_addr(csr_addr),
    .csr_wsrc(csr_wsrc), .csr_rdata(csr_rdata), .pipe_empty(pipe_empty),
    .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .mode(mode), .done(done), .csr(csr)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1ns later; the expected cycle count follows the non-FINISHED states.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!in_fin) exp_cycle++;
  endtask

  task automatic clear_ex();
    ex_valid   = 1'b0;
    ex_inst    = '0;
    ex_illegal = 1'b0;
    ex_pc      = '0;
    csr_addr   = '0;
    csr_wsrc   = '0;
  endtask

  task automatic csr_op(input logic [11:0] addr, input logic [31:0] wsrc, input logic [31:0] exp_rd,
                        input int kind, input string tag);
    clear_ex();
    ex_valid = 1'b1;
    csr_addr = addr;
    csr_wsrc = wsrc;
    case (kind)
      0: ex_inst.CSRRW  = 1'b1;
      1: ex_inst.CSRRS  = 1'b1;
      2: ex_inst.CSRRC  = 1'b1;
      3: ex_inst.CSRRWI = 1'b1;
      default: ex_inst.CSRRCI = 1'b1;
    endcase
    #1;
    check_output({tag, "_rdata"}, csr_rdata, exp_rd);
    tick();
    clear_ex();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_cycle = 32'd0;
    in_fin = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pipe_empty = 1'b0;
    clear_ex();
    tick(); tick();
    exp_cycle = 32'd0;
    check_output("rst_mode", 32'(mode), 32'(FINISHED));
    check_output("rst_stall", 32'(stall), 32'd0);
    check_output("rst_redirect_pc", redirect_pc, 32'd0);
    check_output("rst_mtvec", csr.mtvec, 32'h100);
    check_output("rst_mstatus", csr.mstatus, 32'd0);

    rst = 1'b0;
    tick();
    check_output("fin_stall", 32'(stall), 32'd1);
    check_output("fin_cycle", csr.cycle, 32'd0);

    do_start();
    check_output("start_redirect", 32'(redirect), 32'd1);
    check_output("start_redirect_pc", redirect_pc, 32'h0);
    check_output("start_mode", 32'(mode), 32'(RUNNING));
    tick();
    check_output("run_cycle", csr.cycle, 32'd1);
    check_output("run_stall", 32'(stall), 32'd0);
    check_output("run_redirect", 32'(redirect), 32'd0);

    csr_op(12'h305, 32'h103, 32'h100, 0, "mtvec_w");
    check_output("mtvec_val", csr.mtvec, 32'h103);
    csr_op(12'h300, 32'h8, 32'h0, 3, "mstatus_wi");
    check_output("mstatus_val", csr.mstatus, 32'h8);
    csr_op(12'h300, 32'h0, 32'h8, 1, "mstatus_s0");
    check_output("mstatus_s0_val", csr.mstatus, 32'h8);
    csr_op(12'hC00, 32'h5, exp_cycle, 0, "cycle_w");
    check_output("cycle_ro", csr.cycle, exp_cycle);
    csr_op(12'h305, 32'h100, 32'h103, 2, "mtvec_c");
    check_output("mtvec_c_val", csr.mtvec, 32'h003);
    csr_op(12'h305, 32'h100, 32'h003, 1, "mtvec_s");
    check_output("mtvec_s_val", csr.mtvec, 32'h103);
    csr_op(12'h341, 32'h0000_0037, 32'h0, 0, "mepc_w");
    check_output("mepc_align", csr.mepc, 32'h34);
    csr_op(12'h7FF, 32'hFFFF_FFFF, 32'h0, 0, "unmapped");
    check_output("unmapped_mcause", csr.mcause, 32'h0);

    // ECALL at 0x40 with MIE set: flush at N+1, redirect to mtvec base at N+2.
    ex_valid = 1'b1; ex_inst.ECALL = 1'b1; ex_pc = 32'h40;
    tick();
    clear_ex();
    check_output("ecall_flush", 32'(flush), 32'd1);
    check_output("ecall_stall", 32'(stall), 32'd1);
    check_output("ecall_redirect_n1", 32'(redirect), 32'd0);
    check_output("ecall_mepc", csr.mepc, 32'h40);
    check_output("ecall_mcause", csr.mcause, 32'd11);
    check_output("ecall_mstatus", csr.mstatus, 32'h1880);
    tick();
    check_output("ecall_flush_n2", 32'(flush), 32'd0);
    check_output("ecall_redirect", 32'(redirect), 32'd1);
    check_output("ecall_redirect_pc", redirect_pc, 32'h100);
    tick();
    check_output("ecall_back_run", 32'(stall), 32'd0);

    ex_valid = 1'b1; ex_inst.MRET = 1'b1;
    tick();
    clear_ex();
    check_output("mret_flush", 32'(flush), 32'd1);
    check_output("mret_mstatus", csr.mstatus, 32'h1888);
    tick();
    check_output("mret_redirect_pc", redirect_pc, 32'h40);
    tick();
    check_output("mret_cycle", csr.cycle, exp_cycle);

    ex_valid = 1'b0; ex_inst.ECALL = 1'b1; ex_pc = 32'h60;
    tick();
    clear_ex();
    check_output("novalid_flush", 32'(flush), 32'd0);
    check_output("novalid_mcause", csr.mcause, 32'd11);

    ex_valid = 1'b1; ex_inst.ECALL = 1'b1; ex_illegal = 1'b1; ex_pc = 32'h80;
    tick();
    clear_ex();
    check_output("illegal_mcause", csr.mcause, 32'd2);
    check_output("illegal_mepc", csr.mepc, 32'h80);
    check_output("illegal_flush", 32'(flush), 32'd1);

    // Reset lands while the trap is in S_TRAP.
    rst = 1'b1;
    tick();
    exp_cycle = 32'd0; in_fin = 1'b1;
    rst = 1'b0;
    check_output("rst_trap_mode", 32'(mode), 32'(FINISHED));
    check_output("rst_trap_flush", 32'(flush), 32'd0);
    check_output("rst_trap_redirect", 32'(redirect), 32'd0);
    check_output("rst_trap_mcause", csr.mcause, 32'd0);
    check_output("rst_trap_mepc", csr.mepc, 32'd0);
    check_output("rst_trap_mtvec", csr.mtvec, 32'h100);
    check_output("rst_trap_mstatus", csr.mstatus, 32'd0);
    check_output("rst_trap_cycle", csr.cycle, 32'd0);

    do_start();
    tick();
    ex_valid = 1'b1; ex_inst.EBREAK = 1'b1; ex_inst.MRET = 1'b1; ex_pc = 32'h44;
    tick();
    clear_ex();
    check_output("ebreak_mcause", csr.mcause, 32'd3);
    check_output("ebreak_mstatus", csr.mstatus, 32'h1800);
    tick();
    check_output("ebreak_redirect_pc", redirect_pc, 32'h100);
    tick();

    ex_valid = 1'b1; ex_inst.EXT = 1'b1; pipe_empty = 1'b0;
    tick();
    clear_ex();
    check_output("ext_mode", 32'(mode), 32'(EXITPROC));
    check_output("ext_stall", 32'(stall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("drain_mode", 32'(mode), 32'(EXITPROC));
      check_output("drain_done", 32'(done), 32'd0);
    end
    pipe_empty = 1'b1;
    tick();
    in_fin = 1'b1;
    check_output("exit_mode", 32'(mode), 32'(FINISHED));
    check_output("exit_done", 32'(done), 32'd1);
    check_output("exit_flush", 32'(flush), 32'd0);
    tick();
    check_output("exit_done_pulse", 32'(done), 32'd0);
    check_output("fin_cycle_hold", csr.cycle, exp_cycle);

    start = 1'b0;
    ex_valid = 1'b1; ex_inst.ECALL = 1'b1;
    tick();
    clear_ex();
    check_output("fin_ignore_ex", 32'(mode), 32'(FINISHED));
    check_output("fin_ignore_mcause", csr.mcause, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
